// File: rtl/siso_layer_scheduler_if.sv
// Read-side bus between decoder control and the SISO layer scheduler.
// Carries parity_ok only when EARLY_TERM_EN is defined.
interface siso_layer_scheduler_if #(
  parameter int ADDRWIDTH = 5,
  parameter int ITERBITS  = 4
);
  logic                 start;
  logic [ITERBITS-1:0]  max_iter;
  logic                 rdlayer;
  logic [ADDRWIDTH-1:0] rdaddress;
  logic                 rden_LLR;
  logic                 rden_E;
  logic                 busy;
  logic                 done;
  logic [ITERBITS-1:0]  iter_count;
`ifdef EARLY_TERM_EN
  logic                 parity_ok;

  modport master (
    output start, max_iter, parity_ok,
    input  rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count
  );
  modport slave (
    input  start, max_iter, parity_ok,
    output rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count
  );
`else
  modport master (
    output start, max_iter,
    input  rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count
  );
  modport slave (
    input  start, max_iter,
    output rdlayer, rdaddress, rden_LLR, rden_E, busy, done, iter_count
  );
`endif
endinterface

// File: rtl/siso_layer_scheduler.sv
// Read-side sequencer for one SISO row unit: sweeps addresses per layer per iteration
// with a drain gap after each layer. Optional early termination via EARLY_TERM_EN.
module siso_layer_scheduler #(
  parameter int ADDRWIDTH    = 5,
  parameter int ADDRDEPTH    = 20,
  parameter int LAYERS       = 2,
  parameter int ITERBITS     = 4,
  parameter int DRAIN_CYCLES = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  siso_layer_scheduler_if.slave  bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_LAST  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [DW-1:0]        DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic                 LAYER_LAST = 1'(LAYERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [DW-1:0]       drain_cnt;
  logic [ITERBITS-1:0] last_iter;
  logic                early;

`ifdef EARLY_TERM_EN
  assign early = bus.parity_ok;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      last_iter      <= '0;
      bus.rdlayer    <= 1'b0;
      bus.rdaddress  <= '0;
      bus.rden_LLR   <= 1'b0;
      bus.rden_E     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.iter_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= RUN;
            // max_iter==0 runs one iteration, same as max_iter==1
            last_iter      <= (bus.max_iter == '0) ? '0 : bus.max_iter - 1'b1;
            bus.rdlayer    <= 1'b0;
            bus.rdaddress  <= '0;
            bus.rden_LLR   <= 1'b1;
            bus.rden_E     <= 1'b0;
            bus.busy       <= 1'b1;
            bus.iter_count <= '0;
          end
        end
        RUN: begin
          if (bus.rdaddress == ADDR_LAST) begin
            state        <= DRAIN;
            drain_cnt    <= '0;
            bus.rden_LLR <= 1'b0;
            bus.rden_E   <= 1'b0;
          end else begin
            bus.rdaddress <= bus.rdaddress + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt != DRAIN_LAST) begin
            drain_cnt <= drain_cnt + 1'b1;
          end else if (bus.rdlayer != LAYER_LAST) begin
            state         <= RUN;
            bus.rdlayer   <= bus.rdlayer + 1'b1;
            bus.rdaddress <= '0;
            bus.rden_LLR  <= 1'b1;
            bus.rden_E    <= (bus.iter_count != '0);
          end else if (bus.iter_count == last_iter || early) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            // next iteration always has a previous E to read
            state          <= RUN;
            bus.iter_count <= bus.iter_count + 1'b1;
            bus.rdlayer    <= 1'b0;
            bus.rdaddress  <= '0;
            bus.rden_LLR   <= 1'b1;
            bus.rden_E     <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
